// File: rtl/fx_dot_bias_unit_pkg.sv
// Shared definitions for the Q16.16 dot-product / bias unit.
// Build option: FXDP_SATURATE_EN selects saturating adds (otherwise wrap mod 2^32).
package fx_dot_bias_unit_pkg;

  localparam int FRAC_BITS = 16;
  localparam int WORD      = 32;

  localparam logic [WORD-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [WORD-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ADD, S_DONE} top_state_e;
  typedef enum logic       {A_IDLE, A_DONE}               add_state_e;

  // Full 64-bit signed product, arithmetic shift by FRAC_BITS, keep 32 bits.
  // Dropping the low fraction bits of a two's complement value floors it.
  function automatic logic [WORD-1:0] fx_mul(input logic [WORD-1:0] a, input logic [WORD-1:0] b);
    logic signed [2*WORD-1:0] p;
    p = $signed({{WORD{a[WORD-1]}}, a}) * $signed({{WORD{b[WORD-1]}}, b});
    return p[FRAC_BITS+WORD-1:FRAC_BITS];
  endfunction

  // Accumulate / bias add; overflow behaviour is a build-time choice.
  function automatic logic [WORD-1:0] fx_add(input logic [WORD-1:0] a, input logic [WORD-1:0] b);
`ifdef FXDP_SATURATE_EN
    logic [WORD:0] s;
    s = {a[WORD-1], a} + {b[WORD-1], b};
    if (s[WORD] != s[WORD-1]) return s[WORD] ? SAT_MIN : SAT_MAX;
    return s[WORD-1:0];
`else
    return a + b;
`endif
  endfunction

endpackage

// File: rtl/fx_dot_bias_unit_bias_adder.sv
// fx_bias_adder: four-phase handshaked value + bias adder.
// Overflow handling follows FXDP_SATURATE_EN through fx_add.
module fx_bias_adder
  import fx_dot_bias_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  output logic            done,
  input  logic [WORD-1:0] value_in,
  input  logic [WORD-1:0] bias,
  output logic [WORD-1:0] value_out
);

  add_state_e      state_q;
  logic            done_q;
  logic [WORD-1:0] value_q;

  // Compute once per request, hold done until the requester lets go of start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= A_IDLE;
      done_q  <= 1'b0;
      value_q <= '0;
    end else begin
      case (state_q)
        A_IDLE: if (start) begin
          value_q <= fx_add(value_in, bias);
          done_q  <= 1'b1;
          state_q <= A_DONE;
        end
        A_DONE: if (!start) begin
          done_q  <= 1'b0;
          state_q <= A_IDLE;
        end
        default: state_q <= A_IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign value_out = value_q;

endmodule

// File: rtl/fx_dot_bias_unit.sv
// fx_dot_bias_unit: sequential Q16.16 dot product (one MAC per cycle) plus bias.
// Build option: FXDP_SATURATE_EN makes accumulation and bias add saturating.
module fx_dot_bias_unit
  import fx_dot_bias_unit_pkg::*;
#(
  parameter int MAX_VECTOR_SIZE = 3
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  output logic                            done,
  input  logic [3:0]                      vector_length,
  input  logic [WORD*MAX_VECTOR_SIZE-1:0] vector_a_flat,
  input  logic [WORD*MAX_VECTOR_SIZE-1:0] vector_b_flat,
  input  logic [WORD-1:0]                 bias,
  output logic [WORD-1:0]                 result
);

  localparam logic [3:0] MAXL = 4'(MAX_VECTOR_SIZE);

  // 16-entry views so a 4-bit index always lands in range; unused slots read 0.
  logic [15:0][WORD-1:0] a_v, b_v;

  for (genvar i = 0; i < 16; i++) begin : g_unpack
    if (i < MAX_VECTOR_SIZE) begin : g_on
      assign a_v[i] = vector_a_flat[i*WORD +: WORD];
      assign b_v[i] = vector_b_flat[i*WORD +: WORD];
    end else begin : g_off
      assign a_v[i] = '0;
      assign b_v[i] = '0;
    end
  end

  top_state_e      state_q;
  logic [3:0]      len_q, idx_q;
  logic [WORD-1:0] acc_q, result_q;
  logic            add_start_q, done_q;
  logic            add_done;
  logic [WORD-1:0] add_val;
  logic [3:0]      len_clamped;

  assign len_clamped = (vector_length > MAXL) ? MAXL : vector_length;

  fx_bias_adder u_bias_adder (
    .clk       (clk),
    .rstn      (rstn),
    .start     (add_start_q),
    .done      (add_done),
    .value_in  (acc_q),
    .bias      (bias),
    .value_out (add_val)
  );

  // Job sequencer: latch length, one MAC per edge, hand off to the bias adder, hold done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      add_start_q <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          len_q   <= len_clamped;
          acc_q   <= '0;
          idx_q   <= '0;
          state_q <= S_MAC;
        end
        S_MAC: if (idx_q < len_q) begin
          acc_q <= fx_add(acc_q, fx_mul(a_v[idx_q], b_v[idx_q]));
          idx_q <= idx_q + 4'd1;
        end else begin
          add_start_q <= 1'b1;
          state_q     <= S_ADD;
        end
        S_ADD: if (add_done) begin
          result_q    <= add_val;
          done_q      <= 1'b1;
          add_start_q <= 1'b0;
          state_q     <= S_DONE;
        end
        S_DONE: if (!start) begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_fx_dot_bias_unit.sv
// Bench for fx_dot_bias_unit: directed vector table, handshake/reset sequences,
// and random jobs checked against a plain-arithmetic reference model.
module tb_fx_dot_bias_unit;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          done;
  logic [3:0]    vector_length = '0;
  logic [32*N-1:0] va = '0, vb = '0;
  logic [31:0]   bias = '0;
  logic [31:0]   result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fx_dot_bias_unit #(.MAX_VECTOR_SIZE(N)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .done          (done),
    .vector_length (vector_length),
    .vector_a_flat (va),
    .vector_b_flat (vb),
    .bias          (bias),
    .result        (result)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: real-number semantics of Q16.16 with floor on the product.
  function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y);
    longint s;
    s = longint'($signed(x)) + longint'($signed(y));
`ifdef FXDP_SATURATE_EN
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  function automatic logic [31:0] model(input logic [3:0] len, input logic [32*N-1:0] a,
                                        input logic [32*N-1:0] b, input logic [31:0] bs);
    int n;
    logic [31:0] acc;
    n = (int'(len) > N) ? N : int'(len);
    acc = '0;
    for (int i = 0; i < n; i++) begin
      longint p;
      p = longint'($signed(a[i*32 +: 32])) * longint'($signed(b[i*32 +: 32]));
      p = p >>> 16;
      acc = m_add(acc, p[31:0]);
    end
    return m_add(acc, bs);
  endfunction

  // Launch a job and wait for done; lat counts edges after the one sampling start.
  task automatic run_job(input logic [3:0] len, input logic [32*N-1:0] a, input logic [32*N-1:0] b,
                         input logic [31:0] bs, output int lat);
    int edges;
    @(negedge clk);
    vector_length = len; va = a; vb = b; bias = bs; start = 1'b1;
    edges = 0;
    lat = -1;
    while (edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (done) begin lat = edges - 1; break; end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL timeout: done not seen within 40 edges (len=%0d)", len);
    end
  endtask

  task automatic release_chk(input string name);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk(name, {31'd0, done}, 32'd0);
  endtask

  function automatic int clampl(input logic [3:0] len);
    return (int'(len) > N) ? N : int'(len);
  endfunction

  typedef struct {
    string         name;
    logic [3:0]    len;
    logic [32*N-1:0] a, b;
    logic [31:0]   bs;
    logic [31:0]   exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int lat;
    logic [3:0] len;
    logic [32*N-1:0] a, b;
    logic [31:0] bs, e;

    // element 0 sits in the low word
    tbl[0] = '{"basic", 4'd3, {32'h0003_0000, 32'h0002_0000, 32'h0001_0000},
               {32'h0006_0000, 32'h0005_0000, 32'h0004_0000}, 32'h0000_8000, 32'h0020_8000};
    tbl[1] = '{"len0", 4'd0, {3{32'h0001_0000}}, {3{32'h0001_0000}}, 32'hFFFF_0000, 32'hFFFF_0000};
    tbl[2] = '{"clamp15", 4'd15, {3{32'h0001_0000}}, {3{32'h0001_0000}}, 32'h0, 32'h0003_0000};
    // 32767*2 does not fit Q16.16: each truncated product is -2.0
    tbl[3] = '{"big_prod", 4'd3, {3{32'h7FFF_0000}}, {3{32'h0002_0000}}, 32'h0, 32'hFFFA_0000};
`ifdef FXDP_SATURATE_EN
    tbl[4] = '{"acc_pos_ovf", 4'd3, {3{32'h3FFF_0000}}, {3{32'h0002_0000}}, 32'h0, 32'h7FFF_FFFF};
    tbl[5] = '{"acc_neg_ovf", 4'd2, {3{32'hC000_0000}}, {3{32'h0002_0000}}, 32'h0, 32'h8000_0000};
    tbl[6] = '{"bias_ovf", 4'd1, {3{32'h0001_0000}}, {3{32'h7FFF_0000}}, 32'h0001_0000, 32'h7FFF_FFFF};
`else
    tbl[4] = '{"acc_pos_ovf", 4'd3, {3{32'h3FFF_0000}}, {3{32'h0002_0000}}, 32'h0, 32'h7FFA_0000};
    tbl[5] = '{"acc_neg_ovf", 4'd2, {3{32'hC000_0000}}, {3{32'h0002_0000}}, 32'h0, 32'h0000_0000};
    tbl[6] = '{"bias_ovf", 4'd1, {3{32'h0001_0000}}, {3{32'h7FFF_0000}}, 32'h0001_0000, 32'h8000_0000};
`endif
    tbl[7] = '{"signed_mix", 4'd2, {32'h0, 32'h0002_4000, 32'hFFFE_8000},
               {32'h1234_5678, 32'hFFFF_0000, 32'h0002_0000}, 32'h0, 32'hFFFA_C000};
    tbl[8] = '{"floor_round", 4'd1, {3{32'h0000_0001}}, {3{32'hFFFF_FFFF}}, 32'h0, 32'hFFFF_FFFF};

    // reset state
    #23;
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk); rstn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_job(tbl[i].len, tbl[i].a, tbl[i].b, tbl[i].bs, lat);
      chk({tbl[i].name, "_result"}, result, tbl[i].exp);
      chk({tbl[i].name, "_latency"}, lat, clampl(tbl[i].len) + 3);
      release_chk({tbl[i].name, "_done_fall"});
    end

    // start held after done: done must hold, then fall on the first low sample
    run_job(4'd3, tbl[0].a, tbl[0].b, tbl[0].bs, lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_done", {31'd0, done}, 32'd1);
    end
    chk("hold_result", result, 32'h0020_8000);
    release_chk("hold_done_fall");
    run_job(4'd2, tbl[7].a, tbl[7].b, tbl[7].bs, lat);
    chk("restart_result", result, 32'hFFFA_C000);
    release_chk("restart_done_fall");

    // start dropped early: job still completes with a single-cycle done
    @(negedge clk);
    vector_length = 4'd3; va = tbl[2].a; vb = tbl[2].b; bias = 32'h0000_4000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    chk("early_latency", lat, 6);
    chk("early_result", result, 32'h0003_4000);
    @(posedge clk); #1;
    chk("early_done_one_cycle", {31'd0, done}, 32'd0);

    // reset during MAC aborts the job
    @(negedge clk);
    vector_length = 4'd3; va = tbl[0].a; vb = tbl[0].b; bias = tbl[0].bs; start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b0; #1;
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("abort_no_done", {31'd0, done}, 32'd0);
    @(negedge clk); rstn = 1'b1;
    run_job(4'd3, tbl[0].a, tbl[0].b, tbl[0].bs, lat);
    chk("post_abort_result", result, 32'h0020_8000);
    chk("post_abort_latency", lat, 6);
    release_chk("post_abort_done_fall");

    // randomized jobs against the reference model
    for (int j = 0; j < 40; j++) begin
      len = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        logic [31:0] ea, eb;
        ea = $urandom; eb = $urandom;
        if (j % 2 == 0) begin
          ea = 32'($signed(ea) >>> 10);
          eb = 32'($signed(eb) >>> 10);
        end
        a[i*32 +: 32] = ea;
        b[i*32 +: 32] = eb;
      end
      bs = $urandom;
      e = model(len, a, b, bs);
      run_job(len, a, b, bs, lat);
      chk("rand_result", result, e);
      chk("rand_latency", lat, clampl(len) + 3);
      release_chk("rand_done_fall");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
